sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock parametrised FIFO: storage plus full pointer/flag control in one block.
//  Supports non-power-of-two depth, occupancy count, almost-full/almost-empty thresholds,
//  selectable show-ahead or registered read data, synchronous flush and sticky error flags.
//  Sits between a producer and consumer in the same clock domain. Replaces hand-wired
//  mem-plus-pointer pairs wherever no clock crossing is needed.
// PARAMETERS
//  DATA_WIDTH  8    data word width in bits
//  DEPTH       90   number of entries; any value >= 2; need not be a power of two
//  AF_THRESH   80   almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   8    almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
//  REG_OUT     0    0 = show-ahead (data_out = head entry, combinational); 1 = registered read
//  CW          derived, $clog2(DEPTH+1): count width. Pointer width is $clog2(DEPTH).
// PORTS
//  clk           in   1           single clock; all logic on posedge
//  rst_n         in   1           synchronous reset, active low
//  w_en          in   1           write request
//  data_in       in   DATA_WIDTH  write data
//  r_en          in   1           read request (pop)
//  data_out      out  DATA_WIDTH  read data
//  flush         in   1           synchronous clear of FIFO contents (pointers/count)
//  err_clr       in   1           clears sticky overflow/underflow
//  full          out  1           count == DEPTH
//  empty         out  1           count == 0
//  almost_full   out  1           count >= AF_THRESH
//  almost_empty  out  1           count <= AE_THRESH
//  count         out  CW          current occupancy, 0..DEPTH
//  overflow      out  1           sticky: write attempted while full
//  underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wptr=rptr=0, count=0, overflow=underflow=0,
//    data_out register=0 (REG_OUT=1). Flags follow: empty=1, full=0, almost_empty=1,
//    almost_full=0. Memory array is not reset. Reset overrides every other input.
//  - wr_acc = w_en & !full; rd_acc = r_en & !empty. Flags evaluated on pre-edge count.
//  - wr_acc: mem[wptr] <= data_in; wptr <= (wptr==DEPTH-1) ? 0 : wptr+1.
//  - rd_acc: rptr <= (rptr==DEPTH-1) ? 0 : rptr+1. Explicit wrap; no modulo-2^n.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
//  - Simultaneous w_en & r_en: when full, read accepted, write rejected, overflow set;
//    when empty, write accepted, read rejected, underflow set; otherwise both accepted.
//  - No read-through of same-cycle write: empty FIFO with write shows data next cycle.
//  - full/empty/almost_* are combinational decodes of registered count (no extra delay).
//  - REG_OUT=0: data_out = mem[rptr] continuously; valid whenever empty=0; latency 0.
//  - REG_OUT=1: on rd_acc, data_out <= mem[rptr]; holds value otherwise; latency 1 cycle
//    from accepted r_en to data.
//  - flush=1 (rst_n=1): wptr=rptr=count=0 next cycle; w_en/r_en that cycle ignored;
//    overflow/underflow and data_out register keep their values.
//  - Sticky flags: set on rejected request, cleared by err_clr; set wins over clear
//    in the same cycle.
// TESTING
//  1. Reset, DEPTH=90: write 90 words 0x00..0x59 -> full=1 and count=90 after 90th
//     cycle; 91st write rejected, overflow=1, count stays 90.
//  2. Drain all 90 -> data order 0x00..0x59, empty=1; extra r_en -> underflow=1,
//     data/count unchanged.
//  3. Wrap: fill 60, read 50, write 70 (wptr wraps at 89->0) -> count=80,
//     almost_full=1, read order intact across wrap.
//  4. Full + w_en&r_en -> count 90->89, overflow=1; empty + w_en&r_en -> count 0->1,
//     underflow=1.
//  5. REG_OUT=1: write 0xA5, r_en one cycle -> data_out=0xA5 exactly one clk later;
//     REG_OUT=0: data_out=0xA5 the cycle after write with no r_en.
//  6. Count=40, assert flush with w_en -> count=0, empty=1 next cycle; rst_n low
//     mid-burst -> all outputs to reset values on that edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with non-power-of-two depth, occupancy count, threshold flags,
// optional registered read data, synchronous flush and sticky overflow/underflow.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 90,
  parameter int AF_THRESH  = 80,
  parameter int AE_THRESH  = 8,
  parameter int REG_OUT    = 0,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count_q;
  logic                  wr_acc;
  logic                  rd_acc;

  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A flush cycle ignores both requests, so it also accepts nothing.
  assign wr_acc = w_en & ~full & ~flush;
  assign rd_acc = r_en & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr <= (wptr == LAST_C) ? '0 : wptr + 1'b1;
      if (rd_acc) rptr <= (rptr == LAST_C) ? '0 : rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Setting a sticky flag takes priority over clearing it in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (w_en && full)     overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (r_en && empty)    underflow <= 1'b1;
      else if (err_clr)     underflow <= 1'b0;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rptr];
      end
      assign data_out = dout_q;
    end else begin : g_show_ahead
      assign data_out = mem[rptr];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed checks of sync_fifo_param (show-ahead and registered
// instances driven in parallel) against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DEPTH = 90;
  localparam int AF    = 80;
  localparam int AE    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    data_in = '0;

  logic [7:0]    data_out, data_out_r;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic          full_r, empty_r, almost_full_r, almost_empty_r, overflow_r, underflow_r;
  logic [CW-1:0] count, count_r;

  logic [7:0]    q [$];
  logic          m_ov, m_un;
  logic [7:0]    m_rdata;
  int            checks = 0;
  int            passes = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .REG_OUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .flush(flush), .err_clr(err_clr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .REG_OUT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out_r), .flush(flush), .err_clr(err_clr), .full(full_r), .empty(empty_r),
    .almost_full(almost_full_r), .almost_empty(almost_empty_r), .count(count_r),
    .overflow(overflow_r), .underflow(underflow_r));

  // Expected {full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [5:0] exp_flags();
    int n = q.size();
    return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ov, m_un};
  endfunction

  function automatic logic [5:0] obs_flags();
    return {full, empty, almost_full, almost_empty, overflow, underflow};
  endfunction

  function automatic logic [5:0] obs_flags_r();
    return {full_r, empty_r, almost_full_r, almost_empty_r, overflow_r, underflow_r};
  endfunction

  // Reference model step: applies one clock edge of FIFO rules to the queue.
  task automatic model_step(input logic w, input logic r, input logic [7:0] d,
                            input logic fl, input logic ec, input logic rn);
    int  n = q.size();
    logic is_full  = (n == DEPTH);
    logic is_empty = (n == 0);
    if (!rn) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rdata = 8'h00;
    end else if (fl) begin
      q.delete();
    end else begin
      if (r && !is_empty) m_rdata = q.pop_front();
      if (w && !is_full) q.push_back(d);
      if (w && is_full) m_ov = 1'b1; else if (ec) m_ov = 1'b0;
      if (r && is_empty) m_un = 1'b1; else if (ec) m_un = 1'b0;
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d,
                       input logic fl = 1'b0, input logic ec = 1'b0, input logic rn = 1'b1);
    w_en = w; r_en = r; data_in = d; flush = fl; err_clr = ec; rst_n = rn;
    @(posedge clk);
    model_step(w, r, d, fl, ec, rn);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else passes++;
    checks++; if (obs_flags() !== 6'b010100) $display("FAIL reset_flags: got %b expected 010100", obs_flags()); else passes++;
    checks++; if (data_out_r !== 8'h00) $display("FAIL reset_dout_reg: got %h expected 00", data_out_r); else passes++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i));
    checks++; if (count !== CW'(90)) $display("FAIL fill_count: got %0d expected 90", count); else passes++;
    checks++; if (obs_flags() !== 6'b101000) $display("FAIL fill_flags: got %b expected 101000", obs_flags()); else passes++;
    cycle(1'b1, 1'b0, 8'hEE);
    checks++; if (count !== CW'(90)) $display("FAIL overflow_count: got %0d expected 90", count); else passes++;
    checks++; if (obs_flags() !== 6'b101010) $display("FAIL overflow_flags: got %b expected 101010", obs_flags()); else passes++;
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (data_out !== 8'(i)) $display("FAIL drain_show_ahead[%0d]: got %h expected %h", i, data_out, 8'(i)); else passes++;
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (data_out_r !== 8'(i)) $display("FAIL drain_reg[%0d]: got %h expected %h", i, data_out_r, 8'(i)); else passes++;
    end
    checks++; if (obs_flags() !== exp_flags()) $display("FAIL drain_flags: got %b expected %b", obs_flags(), exp_flags()); else passes++;
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (obs_flags() !== 6'b010111) $display("FAIL underflow_flags: got %b expected 010111", obs_flags()); else passes++;
    checks++; if (count !== '0) $display("FAIL underflow_count: got %0d expected 0", count); else passes++;
    checks++; if (data_out_r !== 8'h59) $display("FAIL underflow_dout: got %h expected 59", data_out_r); else passes++;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (obs_flags() !== 6'b010100) $display("FAIL err_clr_flags: got %b expected 010100", obs_flags()); else passes++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 8'($urandom));
    checks++; if (count !== CW'(80)) $display("FAIL wrap_count: got %0d expected 80", count); else passes++;
    checks++; if (obs_flags() !== 6'b001000) $display("FAIL wrap_flags: got %b expected 001000", obs_flags()); else passes++;
    while (q.size() > 0) begin
      checks++; if (data_out !== q[0]) $display("FAIL wrap_order: got %h expected %h", data_out, q[0]); else passes++;
      cycle(1'b0, 1'b1, 8'h00);
      checks++; if (data_out_r !== m_rdata) $display("FAIL wrap_order_reg: got %h expected %h", data_out_r, m_rdata); else passes++;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    checks++; if (count !== CW'(89)) $display("FAIL sim_full_count: got %0d expected 89", count); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL sim_full_overflow: got %b expected 1", overflow); else passes++;
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'h3C);
    checks++; if (count !== CW'(1)) $display("FAIL sim_empty_count: got %0d expected 1", count); else passes++;
    checks++; if (obs_flags() !== 6'b000101) $display("FAIL sim_empty_flags: got %b expected 000101", obs_flags()); else passes++;
    checks++; if (data_out !== 8'h3C) $display("FAIL sim_empty_data: got %h expected 3c", data_out); else passes++;
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reg_out();
    cycle(1'b1, 1'b0, 8'hA5);
    checks++; if (data_out !== 8'hA5) $display("FAIL show_ahead_a5: got %h expected a5", data_out); else passes++;
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (data_out_r !== 8'hA5) $display("FAIL reg_out_a5: got %h expected a5", data_out_r); else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL reg_out_empty: got %b expected 1", empty); else passes++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 8'($urandom));
    checks++; if (count !== CW'(40)) $display("FAIL pre_flush_count: got %0d expected 40", count); else passes++;
    cycle(1'b1, 1'b1, 8'h11, 1'b1);
    checks++; if (count !== '0) $display("FAIL flush_count: got %0d expected 0", count); else passes++;
    checks++; if (obs_flags() !== exp_flags()) $display("FAIL flush_flags: got %b expected %b", obs_flags(), exp_flags()); else passes++;
    checks++; if (data_out_r !== m_rdata) $display("FAIL flush_dout_hold: got %h expected %h", data_out_r, m_rdata); else passes++;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'($urandom));
    cycle(1'b1, 1'b0, 8'h99);
    cycle(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== '0) $display("FAIL midburst_rst_count: got %0d expected 0", count); else passes++;
    checks++; if (obs_flags() !== 6'b010100) $display("FAIL midburst_rst_flags: got %b expected 010100", obs_flags()); else passes++;
    checks++; if (data_out_r !== 8'h00) $display("FAIL midburst_rst_dout: got %h expected 00", data_out_r); else passes++;
  endtask

  task automatic test_random();
    logic w, r, fl, ec;
    for (int i = 0; i < 3000; i++) begin
      w  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 65 : 35));
      r  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 65));
      fl = ($urandom_range(0, 199) == 0);
      ec = ($urandom_range(0, 19) == 0);
      cycle(w, r, 8'($urandom), fl, ec);
      checks++; if (count !== CW'(q.size()) || count_r !== CW'(q.size()))
        $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d", i, count, count_r, q.size()); else passes++;
      checks++; if (obs_flags() !== exp_flags() || obs_flags_r() !== exp_flags())
        $display("FAIL rand_flags[%0d]: got %b/%b expected %b", i, obs_flags(), obs_flags_r(), exp_flags()); else passes++;
      checks++; if (data_out_r !== m_rdata) $display("FAIL rand_dout_reg[%0d]: got %h expected %h", i, data_out_r, m_rdata); else passes++;
      if (q.size() > 0) begin
        checks++; if (data_out !== q[0]) $display("FAIL rand_dout[%0d]: got %h expected %h", i, data_out, q[0]); else passes++;
      end
    end
  endtask

  initial begin
    m_ov = 1'b0; m_un = 1'b0; m_rdata = 8'h00;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_wrap();
    test_simultaneous();
    test_reg_out();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
